// File: rtl/pipe_ctrl_pkg.sv
// Shared constants and state type for the pipeline hazard/sequencing controller.
package pipe_ctrl_pkg;

    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;

    localparam logic [6:0] FUNCT7_MULDIV = 7'b0000001;

    typedef enum logic {
        RUN,
        EX_WAIT
    } ex_state_t;

endpackage

// File: rtl/instr_use_decode.sv
// Register-field extraction and source-operand usage decode for one instruction.
module instr_use_decode
    import pipe_ctrl_pkg::*;
(
    input  logic [31:0] instr,
    output logic [4:0]  rd,
    output logic [4:0]  rs1,
    output logic [4:0]  rs2,
    output logic        uses_rs1,
    output logic        uses_rs2
);

    logic [6:0] opcode;
    logic       unused_fields;

    assign opcode = instr[6:0];
    assign rd     = instr[11:7];
    assign rs1    = instr[19:15];
    assign rs2    = instr[24:20];

    assign uses_rs1 = (opcode != OPC_LUI) && (opcode != OPC_AUIPC) && (opcode != OPC_JAL);
    assign uses_rs2 = (opcode == OPC_OP) || (opcode == OPC_STORE) || (opcode == OPC_BRANCH);

    assign unused_fields = ^{instr[31:25], instr[14:12]};

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Stall/flush controller: load-use bubbles, redirect squashes and divider sequencing.
// Optional PIPE_HAZARD_CTRL_PERF_EN adds saturating perf counter outputs.
module pipe_hazard_ctrl
    import pipe_ctrl_pkg::*;
#(
    parameter int unsigned MAX_EX_CYC = 64
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] Instr_D,
    input  logic [31:0] Instr_E,
    input  logic        br_taken_E,
    input  logic        ex_done,
    output logic        stall_F,
    output logic        stall_D,
    output logic        stall_E,
    output logic        flush_D,
    output logic        flush_E,
    output logic        flush_M,
    output logic        ex_start,
    output logic        ex_abort,
    output logic        ex_timeout
`ifdef PIPE_HAZARD_CTRL_PERF_EN
    ,
    output logic [31:0] perf_lu_stall,
    output logic [31:0] perf_flush,
    output logic [31:0] perf_ex_wait
`endif
);

    localparam int unsigned CW = $clog2(MAX_EX_CYC + 1);
    localparam logic [CW-1:0] LAST_CNT = CW'(MAX_EX_CYC - 1);

    logic [4:0] rd_D, rs1_D, rs2_D, rd_E, rs1_E, rs2_E;
    logic       uses_rs1_D, uses_rs2_D, uses_rs1_E, uses_rs2_E;
    logic       load_use, is_div_E, div_stall, timeout_set;
    logic       unused_dec;

    ex_state_t     state, state_nxt;
    logic [CW-1:0] wait_cnt, wait_cnt_nxt;

    instr_use_decode u_dec_d (
        .instr    (Instr_D),
        .rd       (rd_D),
        .rs1      (rs1_D),
        .rs2      (rs2_D),
        .uses_rs1 (uses_rs1_D),
        .uses_rs2 (uses_rs2_D)
    );

    instr_use_decode u_dec_e (
        .instr    (Instr_E),
        .rd       (rd_E),
        .rs1      (rs1_E),
        .rs2      (rs2_E),
        .uses_rs1 (uses_rs1_E),
        .uses_rs2 (uses_rs2_E)
    );

    assign unused_dec = ^{rd_D, rs1_E, rs2_E, uses_rs1_E, uses_rs2_E};

    assign load_use = (Instr_E[6:0] == OPC_LOAD) && (rd_E != 5'd0) &&
                      ((uses_rs1_D && (rs1_D == rd_E)) || (uses_rs2_D && (rs2_D == rd_E)));

    assign is_div_E = (Instr_E[6:0] == OPC_OP) && (Instr_E[31:25] == FUNCT7_MULDIV) && Instr_E[14];

    always_comb begin
        stall_F      = 1'b0;
        stall_D      = 1'b0;
        stall_E      = 1'b0;
        flush_D      = 1'b0;
        flush_E      = 1'b0;
        flush_M      = 1'b0;
        ex_start     = 1'b0;
        ex_abort     = 1'b0;
        div_stall    = 1'b0;
        timeout_set  = 1'b0;
        state_nxt    = state;
        wait_cnt_nxt = wait_cnt;

        case (state)
            RUN: begin
                if (br_taken_E) begin
                    flush_D = 1'b1;
                    flush_E = 1'b1;
                end else if (load_use) begin
                    stall_F = 1'b1;
                    stall_D = 1'b1;
                    flush_E = 1'b1;
                end
                if (is_div_E && !ex_done) begin
                    ex_start     = 1'b1;
                    div_stall    = 1'b1;
                    state_nxt    = EX_WAIT;
                    wait_cnt_nxt = '0;
                end
            end
            EX_WAIT: begin
                if (ex_done) begin
                    state_nxt = RUN;
                end else if (wait_cnt == LAST_CNT) begin
                    ex_abort    = 1'b1;
                    timeout_set = 1'b1;
                    state_nxt   = RUN;
                end else begin
                    div_stall = 1'b1;
                    if (wait_cnt != '1)
                        wait_cnt_nxt = wait_cnt + CW'(1);
                end
            end
            default: state_nxt = RUN;
        endcase

        if (div_stall) begin
            stall_F = 1'b1;
            stall_D = 1'b1;
            stall_E = 1'b1;
            flush_M = 1'b1;
        end

        // Outputs are forced quiet for the whole reset interval, not just after the edge.
        if (!rst_n) begin
            stall_F  = 1'b0;
            stall_D  = 1'b0;
            stall_E  = 1'b0;
            flush_D  = 1'b0;
            flush_E  = 1'b0;
            flush_M  = 1'b0;
            ex_start = 1'b0;
            ex_abort = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= RUN;
            wait_cnt   <= '0;
            ex_timeout <= 1'b0;
        end else begin
            state    <= state_nxt;
            wait_cnt <= wait_cnt_nxt;
            if (timeout_set)
                ex_timeout <= 1'b1;
        end
    end

`ifdef PIPE_HAZARD_CTRL_PERF_EN
    // Events recovered from the outputs: only load-use holds IF/ID without ID/EX,
    // only a redirect flushes IF/ID, and only the divider stalls ID/EX.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            perf_lu_stall <= '0;
            perf_flush    <= '0;
            perf_ex_wait  <= '0;
        end else begin
            if (stall_D && !stall_E && perf_lu_stall != '1)
                perf_lu_stall <= perf_lu_stall + 32'd1;
            if (flush_D && perf_flush != '1)
                perf_flush <= perf_flush + 32'd1;
            if (stall_E && perf_ex_wait != '1)
                perf_ex_wait <= perf_ex_wait + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed bench for pipe_hazard_ctrl: combinational vector table plus divider sequences.
module tb_pipe_hazard_ctrl;

    localparam logic [31:0] NOP    = 32'h00000013;
    localparam logic [31:0] LW_X5  = 32'h0000A283;
    localparam logic [31:0] LW_X0  = 32'h0000A003;
    localparam logic [31:0] ADD    = 32'h00728333;
    localparam logic [31:0] DIV    = 32'h0272C333;
    localparam logic [31:0] REM    = 32'h0272E333;
    localparam logic [31:0] MUL    = 32'h02728333;

    localparam logic [7:0] O_NONE  = 8'h00;
    localparam logic [7:0] O_LU    = 8'hC8;
    localparam logic [7:0] O_RDIR  = 8'h18;
    localparam logic [7:0] O_START = 8'hE6;
    localparam logic [7:0] O_WAIT  = 8'hE4;
    localparam logic [7:0] O_ABORT = 8'h01;

    typedef struct {
        logic [31:0] d;
        logic [31:0] e;
        logic        br;
        logic        done;
        logic [7:0]  exp;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [31:0] instr_d, instr_e;
    logic        br_taken, ex_done;

    logic a_sf, a_sd, a_se, a_fd, a_fe, a_fm, a_start, a_abort, a_to;
    logic b_sf, b_sd, b_se, b_fd, b_fe, b_fm, b_start, b_abort, b_to;
    logic [7:0] a_vec, b_vec;

    int total = 0;
    int bad = 0;

`ifdef PIPE_HAZARD_CTRL_PERF_EN
    logic [31:0] a_perf_lu, a_perf_fl, a_perf_ew, b_perf_lu, b_perf_fl, b_perf_ew;
`endif

    always #5 clk = ~clk;

    pipe_hazard_ctrl dut (
        .clk(clk), .rst_n(rst_n), .Instr_D(instr_d), .Instr_E(instr_e),
        .br_taken_E(br_taken), .ex_done(ex_done),
        .stall_F(a_sf), .stall_D(a_sd), .stall_E(a_se),
        .flush_D(a_fd), .flush_E(a_fe), .flush_M(a_fm),
        .ex_start(a_start), .ex_abort(a_abort), .ex_timeout(a_to)
`ifdef PIPE_HAZARD_CTRL_PERF_EN
        , .perf_lu_stall(a_perf_lu), .perf_flush(a_perf_fl), .perf_ex_wait(a_perf_ew)
`endif
    );

    pipe_hazard_ctrl #(.MAX_EX_CYC(8)) dut8 (
        .clk(clk), .rst_n(rst_n), .Instr_D(instr_d), .Instr_E(instr_e),
        .br_taken_E(br_taken), .ex_done(ex_done),
        .stall_F(b_sf), .stall_D(b_sd), .stall_E(b_se),
        .flush_D(b_fd), .flush_E(b_fe), .flush_M(b_fm),
        .ex_start(b_start), .ex_abort(b_abort), .ex_timeout(b_to)
`ifdef PIPE_HAZARD_CTRL_PERF_EN
        , .perf_lu_stall(b_perf_lu), .perf_flush(b_perf_fl), .perf_ex_wait(b_perf_ew)
`endif
    );

    assign a_vec = {a_sf, a_sd, a_se, a_fd, a_fe, a_fm, a_start, a_abort};
    assign b_vec = {b_sf, b_sd, b_se, b_fd, b_fe, b_fm, b_start, b_abort};

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic next_cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic apply(input logic [31:0] d, input logic [31:0] e, input logic br, input logic done);
        instr_d  = d;
        instr_e  = e;
        br_taken = br;
        ex_done  = done;
        #2;
    endtask

    task automatic rst_pulse();
        rst_n = 1'b0;
        #1;
        rst_n = 1'b1;
    endtask

    vec_t vecs[16];
    int   stall_cnt;

    initial begin
        vecs[0]  = '{NOP,          NOP,          1'b0, 1'b0, O_NONE};
        vecs[1]  = '{ADD,          LW_X5,        1'b0, 1'b0, O_LU};
        vecs[2]  = '{ADD,          LW_X0,        1'b0, 1'b0, O_NONE};
        vecs[3]  = '{32'h000052B7, LW_X5,        1'b0, 1'b0, O_NONE};
        vecs[4]  = '{32'h000282B7, LW_X5,        1'b0, 1'b0, O_NONE};
        vecs[5]  = '{32'h000282EF, LW_X5,        1'b0, 1'b0, O_NONE};
        vecs[6]  = '{32'h00508313, LW_X5,        1'b0, 1'b0, O_NONE};
        vecs[7]  = '{32'h00028313, LW_X5,        1'b0, 1'b0, O_LU};
        vecs[8]  = '{32'h0050A023, LW_X5,        1'b0, 1'b0, O_LU};
        vecs[9]  = '{32'h00508063, LW_X5,        1'b0, 1'b0, O_LU};
        vecs[10] = '{ADD,          LW_X5,        1'b1, 1'b0, O_RDIR};
        vecs[11] = '{NOP,          NOP,          1'b1, 1'b0, O_RDIR};
        vecs[12] = '{ADD,          DIV,          1'b0, 1'b1, O_NONE};
        vecs[13] = '{ADD,          MUL,          1'b0, 1'b0, O_NONE};
        vecs[14] = '{ADD,          32'h00000293, 1'b0, 1'b0, O_NONE};
        vecs[15] = '{32'h00028297, LW_X5,        1'b0, 1'b0, O_NONE};

        // Reset: outputs quiet even with a load-use pattern present.
        rst_n = 1'b0;
        instr_d = ADD; instr_e = LW_X5; br_taken = 1'b1; ex_done = 1'b0;
        #12;
        chk("reset_outs", {24'd0, a_vec}, 32'h0);
        chk("reset_timeout", {31'd0, a_to}, 32'h0);
        br_taken = 1'b0;
        #1;
        chk("reset_lu_masked", {24'd0, a_vec}, 32'h0);
        rst_n = 1'b1;
        next_cyc();

        for (int unsigned i = 0; i < 16; i++) begin
            apply(vecs[i].d, vecs[i].e, vecs[i].br, vecs[i].done);
            chk($sformatf("vec%0d", i), {24'd0, a_vec}, {24'd0, vecs[i].exp});
            next_cyc();
        end

        // Load-use bubble lasts one cycle.
        rst_pulse();
        apply(ADD, LW_X5, 1'b0, 1'b0);
        chk("lu_stall", {24'd0, a_vec}, {24'd0, O_LU});
        next_cyc();
        apply(ADD, NOP, 1'b0, 1'b0);
        chk("lu_bubble", {24'd0, a_vec}, 32'h0);
        next_cyc();

        // DIV with ex_done after 10 wait cycles: 11 stall cycles total.
        apply(ADD, DIV, 1'b0, 1'b0);
        chk("div_start", {24'd0, a_vec}, {24'd0, O_START});
        stall_cnt = int'(a_se);
        for (int k = 0; k < 10; k++) begin
            next_cyc();
            apply(ADD, DIV, (k == 3), 1'b0);
            chk($sformatf("div_wait%0d", k), {24'd0, a_vec}, {24'd0, O_WAIT});
            stall_cnt += int'(a_se);
        end
        next_cyc();
        apply(ADD, DIV, 1'b0, 1'b1);
        chk("div_done", {24'd0, a_vec}, 32'h0);
        stall_cnt += int'(a_se);
        chk("div_stall_cycles", stall_cnt, 11);
        next_cyc();
        apply(ADD, NOP, 1'b0, 1'b0);
        chk("div_back_run", {24'd0, a_vec}, 32'h0);
`ifdef PIPE_HAZARD_CTRL_PERF_EN
        chk("perf_lu_stall", a_perf_lu, 32'd1);
        chk("perf_ex_wait", a_perf_ew, 32'd11);
        chk("perf_flush", a_perf_fl, 32'd0);
`endif
        next_cyc();

        // Back-to-back DIV then REM each get their own start.
        apply(ADD, DIV, 1'b0, 1'b0);
        chk("b2b_start1", {24'd0, a_vec}, {24'd0, O_START});
        next_cyc();
        apply(ADD, DIV, 1'b0, 1'b1);
        chk("b2b_done1", {24'd0, a_vec}, 32'h0);
        next_cyc();
        apply(ADD, REM, 1'b0, 1'b0);
        chk("b2b_start2", {24'd0, a_vec}, {24'd0, O_START});
        next_cyc();
        apply(ADD, REM, 1'b0, 1'b1);
        chk("b2b_done2", {24'd0, a_vec}, 32'h0);
        next_cyc();
        apply(NOP, NOP, 1'b0, 1'b0);

        // Timeout with MAX_EX_CYC=8: start + 7 waits stalled, abort on the next cycle.
        rst_pulse();
        apply(NOP, DIV, 1'b0, 1'b0);
        chk("to_start", {24'd0, b_vec}, {24'd0, O_START});
        for (int k = 0; k < 7; k++) begin
            next_cyc();
            apply(NOP, DIV, 1'b0, 1'b0);
            chk($sformatf("to_wait%0d", k), {24'd0, b_vec}, {24'd0, O_WAIT});
        end
        next_cyc();
        apply(NOP, DIV, 1'b0, 1'b0);
        chk("to_abort", {24'd0, b_vec}, {24'd0, O_ABORT});
        chk("to_flag_pre", {31'd0, b_to}, 32'h0);
        next_cyc();
        apply(NOP, NOP, 1'b0, 1'b0);
        chk("to_after", {24'd0, b_vec}, 32'h0);
        chk("to_flag_set", {31'd0, b_to}, 32'h1);
        for (int k = 0; k < 3; k++) next_cyc();
        chk("to_flag_held", {31'd0, b_to}, 32'h1);

        // New DIV then reset mid-wait clears state, counter and flag without an abort.
        apply(NOP, DIV, 1'b0, 1'b0);
        chk("to_restart", {24'd0, b_vec}, {24'd0, O_START});
        for (int k = 0; k < 3; k++) next_cyc();
        chk("to_rewait", {24'd0, b_vec}, {24'd0, O_WAIT});
        rst_n = 1'b0;
        #1;
        chk("midrst_outs", {24'd0, b_vec}, 32'h0);
        chk("midrst_flag", {31'd0, b_to}, 32'h0);
        next_cyc();
        rst_n = 1'b1;
        #1;
        chk("postrst_run", {24'd0, b_vec}, {24'd0, O_START});
        chk("postrst_flag", {31'd0, b_to}, 32'h0);
        next_cyc();
        apply(NOP, DIV, 1'b0, 1'b1);
        chk("postrst_done", {24'd0, b_vec}, 32'h0);
        next_cyc();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
